fp_accum_seq: RTL and testbench

//  Sequential FP32 accumulator front/back end for the combinational FP32 adder stage.

---
 rtl/fp_acc_pkg.sv | 24 ++
 rtl/fp_acc_bypass.sv | 33 +++
 rtl/fp_accum_seq.sv | 127 ++++++++++++
 tb/tb_fp_accum_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_acc_pkg.sv
// Shared types and FP32 field positions for the sequential FP32 accumulator.
// Contents: FSM state enum, FP32 bit-field localparams, canonical +0 constant,
//           and a small helper that tests for a zero exponent (zero/denormal).
package fp_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SIGN   = 31;
   localparam int EXP_HI = 30;
   localparam int EXP_LO = 23;
   localparam int MAN_W  = 23;

   localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

   // Zero exponent covers both true zero and denormals; both are flushed to zero here.
   function automatic logic exp_is_zero(input logic [31:0] v);
      return (v[EXP_HI:EXP_LO] == 8'h00);
   endfunction

endpackage

// File: rtl/fp_acc_bypass.sv
// Combinational next-accumulator select for the FP32 accumulator.
// Ports: acc (current sum), in_data (sample), add_res (adder result) -> next.
// Covers the cases the adder cannot: zero/denormal operands and exact cancellation.
module fp_acc_bypass
   import fp_acc_pkg::*;
(
   input  logic [31:0] acc,
   input  logic [31:0] in_data,
   input  logic [31:0] add_res,
   output logic [31:0] next
);

   logic w_in_zero;
   logic w_acc_zero;
   logic w_cancel;

   assign w_in_zero  = exp_is_zero(in_data);
   assign w_acc_zero = exp_is_zero(acc);
   // Equal magnitude with opposite signs sums to exactly +0.
   assign w_cancel   = (acc[EXP_HI:0] == in_data[EXP_HI:0]) && (acc[SIGN] != in_data[SIGN]);

   always_comb begin
      next = add_res;
      if (w_in_zero) begin
         next = acc;
      end else if (w_acc_zero) begin
         next = w_in_zero ? FP32_POS_ZERO : in_data;
      end else if (w_cancel) begin
         next = FP32_POS_ZERO;
      end
   end

endmodule

// File: rtl/fp_accum_seq.sv
// Sequential FP32 frame accumulator wrapped around an external combinational FP32 adder.
// Ports: start/len begin a frame; in_valid/in_ready/in_data carry samples; add_a/add_b/add_res
//        talk to the adder; out_valid/out_ready/out_data return the sum; busy = not IDLE.
// Optional: FPACC_ABORT_EN adds an abort input that drops the frame from ACC or DONE.
module fp_accum_seq
   import fp_acc_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   input  logic [31:0]      add_res,
   output logic             out_valid,
   output logic [31:0]      out_data,
   input  logic             out_ready,
`ifdef FPACC_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy
);

   state_t           r_state;
   logic [31:0]      r_acc;
   logic [LEN_W-1:0] r_cnt;
   logic             r_out_valid;
   logic [31:0]      r_out_data;

   state_t           w_state_nxt;
   logic [31:0]      w_acc_nxt;
   logic [LEN_W-1:0] w_cnt_nxt;
   logic             w_out_valid_nxt;
   logic [31:0]      w_out_data_nxt;
   logic [31:0]      w_bypass_next;

   fp_acc_bypass u_bypass (
      .acc     (r_acc),
      .in_data (in_data),
      .add_res (add_res),
      .next    (w_bypass_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= FP32_POS_ZERO;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= FP32_POS_ZERO;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_acc_nxt = FP32_POS_ZERO;
               w_cnt_nxt = len;
               if (len == '0) begin
                  // Empty frame: report +0 straight away.
                  w_state_nxt     = DONE;
                  w_out_valid_nxt = 1'b1;
                  w_out_data_nxt  = FP32_POS_ZERO;
               end else begin
                  w_state_nxt = ACC;
               end
            end
         end
         ACC: begin
            if (in_valid) begin
               w_acc_nxt = w_bypass_next;
               w_cnt_nxt = r_cnt - LEN_W'(1);
               if (r_cnt == LEN_W'(1)) begin
                  // Last beat: the final sum goes straight into the output register.
                  w_state_nxt     = DONE;
                  w_out_valid_nxt = 1'b1;
                  w_out_data_nxt  = w_bypass_next;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_nxt     = IDLE;
               w_out_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_out_valid_nxt = 1'b0;
         end
      endcase
`ifdef FPACC_ABORT_EN
      // Abort wins over a same-cycle beat or out_ready.
      if (abort && (r_state != IDLE)) begin
         w_state_nxt     = IDLE;
         w_acc_nxt       = FP32_POS_ZERO;
         w_cnt_nxt       = '0;
         w_out_valid_nxt = 1'b0;
      end
`endif
   end

   assign in_ready  = (r_state == ACC);
   assign busy      = (r_state != IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign add_a     = r_acc;
   assign add_b     = in_data;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed self-checking bench for fp_accum_seq with a behavioural FP32 adder model.
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
// Define FPACC_ABORT_EN to also exercise the abort path.
module tb_fp_accum_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic [31:0] add_res;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic        busy;
`ifdef FPACC_ABORT_EN
   logic        abort;
`endif

   int n_tests;
   int n_fail;

   fp_accum_seq #(.LEN_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_res   (add_res),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
`ifdef FPACC_ABORT_EN
      .abort     (abort),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural FP32 adder for normal operands (truncating); stands in for the real adder stage.
   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] a, b;
      logic [7:0]  ea, eb, er, d;
      logic [24:0] ma, mb, m;
      if (x[30:0] < y[30:0]) begin
         a = y; b = x;
      end else begin
         a = x; b = y;
      end
      ea = a[30:23];
      eb = b[30:23];
      ma = {2'b01, a[22:0]};
      mb = {2'b01, b[22:0]};
      d  = ea - eb;
      mb = (d > 8'd24) ? 25'd0 : (mb >> d);
      er = ea;
      if (a[31] == b[31]) begin
         m = ma + mb;
         if (m[24]) begin
            m  = m >> 1;
            er = er + 8'd1;
         end
      end else begin
         m = ma - mb;
         if (m == 25'd0) return 32'h0;
         for (int i = 0; i < 24; i++) begin
            if (!m[23]) begin
               m  = m << 1;
               er = er - 8'd1;
            end
         end
      end
      return {a[31], er, m[22:0]};
   endfunction

   always_comb add_res = fp_add(add_a, add_b);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one sample for one cycle, checking the adder operands before the edge.
   task automatic beat(input logic [31:0] d, input logic [31:0] exp_acc, input string tag);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      check({tag, " add_a"}, add_a, exp_acc);
      check({tag, " add_b"}, add_b, d);
      check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic begin_frame(input logic [7:0] n);
      start = 1'b1;
      len   = n;
      tick();
      start = 1'b0;
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      check({tag, " ovld_clr"}, {31'd0, out_valid}, 32'd0);
      check({tag, " idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      len       = 8'd0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;
`ifdef FPACC_ABORT_EN
      abort     = 1'b0;
`endif
      #3;
      check("rst in_ready", {31'd0, in_ready}, 32'd0);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst out_data", out_data, 32'h0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst add_a", add_a, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: 1.0 + 2.0 + 3.0 = 6.0
      begin_frame(8'd3);
      check("t1 busy", {31'd0, busy}, 32'd1);
      check("t1 ovld0", {31'd0, out_valid}, 32'd0);
      beat(32'h3F800000, 32'h00000000, "t1b1");
      beat(32'h40000000, 32'h3F800000, "t1b2");
      check("t1 ovld_mid", {31'd0, out_valid}, 32'd0);
      beat(32'h40400000, 32'h40400000, "t1b3");
      check("t1 out_valid", {31'd0, out_valid}, 32'd1);
      check("t1 out_data", out_data, 32'h40C00000);
      check("t1 in_ready", {31'd0, in_ready}, 32'd0);
      consume("t1");

      // 2: empty frame yields +0 on the next cycle
      begin_frame(8'd0);
      check("t2 out_valid", {31'd0, out_valid}, 32'd1);
      check("t2 out_data", out_data, 32'h0);
      check("t2 in_ready", {31'd0, in_ready}, 32'd0);
      consume("t2");

      // 3: 2.0 + (-2.0) cancels exactly
      begin_frame(8'd2);
      beat(32'h40000000, 32'h00000000, "t3b1");
      beat(32'hC0000000, 32'h40000000, "t3b2");
      check("t3 out_valid", {31'd0, out_valid}, 32'd1);
      check("t3 out_data", out_data, 32'h0);
      consume("t3");

      // 4: zeros flushed, gaps hold state
      begin_frame(8'd3);
      beat(32'h00000000, 32'h00000000, "t4b1");
      tick();
      tick();
      check("t4 gap1 add_a", add_a, 32'h0);
      beat(32'h3F800000, 32'h00000000, "t4b2");
      tick();
      tick();
      check("t4 gap2 add_a", add_a, 32'h3F800000);
      check("t4 gap2 busy", {31'd0, busy}, 32'd1);
      check("t4 gap2 ovld", {31'd0, out_valid}, 32'd0);
      beat(32'h00000000, 32'h3F800000, "t4b3");
      check("t4 out_valid", {31'd0, out_valid}, 32'd1);
      check("t4 out_data", out_data, 32'h3F800000);

      // 5: output held under backpressure; start in DONE ignored
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         len   = 8'd5;
         tick();
         check("t5 hold ovld", {31'd0, out_valid}, 32'd1);
         check("t5 hold data", out_data, 32'h3F800000);
         check("t5 hold in_ready", {31'd0, in_ready}, 32'd0);
      end
      // start held through the out_ready cycle must not be taken that cycle
      start     = 1'b1;
      len       = 8'd2;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t5 b2b idle", {31'd0, busy}, 32'd0);
      check("t5 b2b ovld", {31'd0, out_valid}, 32'd0);
      tick();
      start = 1'b0;
      check("t5 b2b acc", {31'd0, in_ready}, 32'd1);

      // 6: asynchronous reset mid-frame
      beat(32'h3F800000, 32'h00000000, "t6b1");
      check("t6 acc", add_a, 32'h3F800000);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6 rst busy", {31'd0, busy}, 32'd0);
      check("t6 rst in_ready", {31'd0, in_ready}, 32'd0);
      check("t6 rst add_a", add_a, 32'h0);
      check("t6 rst ovld", {31'd0, out_valid}, 32'd0);
      check("t6 rst odata", out_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      begin_frame(8'd1);
      beat(32'h3F800000, 32'h00000000, "t6f");
      check("t6 out_valid", {31'd0, out_valid}, 32'd1);
      check("t6 out_data", out_data, 32'h3F800000);
      consume("t6");

`ifdef FPACC_ABORT_EN
      // 7: abort on the second beat drops the frame
      begin_frame(8'd3);
      beat(32'h3F800000, 32'h00000000, "t7b1");
      abort = 1'b1;
      beat(32'h40000000, 32'h3F800000, "t7b2");
      abort = 1'b0;
      check("t7 busy", {31'd0, busy}, 32'd0);
      check("t7 ovld", {31'd0, out_valid}, 32'd0);
      check("t7 acc", add_a, 32'h0);
      tick();
      check("t7 ovld2", {31'd0, out_valid}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
